prover_chi_expand: RTL and testbench

Consumes the negated point coordinates produced by the output-layer negate shim: the pair (z, 1−z) per bit. Expands them into the full chi (equality-polynomial) table chi[i] = ∏_j (bit_j(i) ? z_j : 1−z_j) over 2^nBits entries. Sits between the negate shim and the output-layer beta/z1_chi consumers. A single shared field multiplier is driven by a level-by-level, in-place doubling sequencer.

---
 rtl/prover_chi_pkg.sv | 40 ++++
 rtl/prover_chi_expand_if.sv | 26 ++
 rtl/field_multiplier.sv | 41 ++++
 rtl/prover_chi_expand.sv | 165 ++++++++++++++++
 tb/tb_prover_chi_expand.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prover_chi_pkg.sv
// prover_chi_pkg: shared types and field constants
// for the chi table expander.
package prover_chi_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] P = 61'h1FFF_FFFF_FFFF_FFFF;

  localparam int NBITS_DEF = 2;
  localparam int TBL_SIZE = 1 << NBITS_DEF;
  localparam int MUL_LAT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_HI_ST,
    ST_HI,
    ST_LO_ST,
    ST_LO,
    ST_NEXT
  } state_t;

  // p = 2^61-1: fold the high half onto the low half twice.
  function automatic logic [F_NBITS-1:0] mod_mul(
    input logic [F_NBITS-1:0] a,
    input logic [F_NBITS-1:0] b
  );
    logic [2*F_NBITS-1:0] prod;
    logic [F_NBITS:0] s1;
    logic [F_NBITS:0] s2;
    prod = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    s1 = {1'b0, prod[F_NBITS-1:0]}
       + {1'b0, prod[2*F_NBITS-1:F_NBITS]};
    s2 = {1'b0, s1[F_NBITS-1:0]}
       + {{F_NBITS{1'b0}}, s1[F_NBITS]};
    if (s2 >= {1'b0, P})
      s2 = s2 - {1'b0, P};
    return s2[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/prover_chi_expand_if.sv
// prover_chi_expand_if: start request, point coordinates
// in, chi table and completion flags out.
interface prover_chi_expand_if
  import prover_chi_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
);

  logic en;
  logic [NBITS-1:0][F_NBITS-1:0] z;
  logic [NBITS-1:0][F_NBITS-1:0] m_z_p1;
  logic [(1<<NBITS)-1:0][F_NBITS-1:0] chi;
  logic ready;
  logic ready_pulse;

  modport master (
    output en, z, m_z_p1,
    input  chi, ready, ready_pulse
  );

  modport slave (
    input  en, z, m_z_p1,
    output chi, ready, ready_pulse
  );

endinterface

// File: rtl/field_multiplier.sv
// field_multiplier: fixed-latency mod-p multiplier;
// c is valid while ready_pulse is high.
module field_multiplier
  import prover_chi_pkg::*;
#(
  parameter int LAT = MUL_LAT
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic               ready_pulse,
  output logic               ready,
  output logic [F_NBITS-1:0] c
);

  logic [F_NBITS-1:0] a_q;
  logic [F_NBITS-1:0] b_q;
  logic [LAT-1:0]     vld;

  // capture operands and shift the issue token down the pipe
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q <= '0;
      b_q <= '0;
      vld <= '0;
    end else begin
      vld <= (vld << 1) | LAT'(en);
      if (en) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign ready_pulse = vld[LAT-1];
  assign ready = ~|vld;
  assign c = mod_mul(a_q, b_q);

endmodule

// File: rtl/prover_chi_expand.sv
// prover_chi_expand: in-place level-doubling chi table
// builder; PROVER_CHI_LEVEL0_BYPASS_EN seeds level 0.
module prover_chi_expand
  import prover_chi_pkg::*;
#(
  parameter int nBits = NBITS_DEF
) (
  input logic clk,
  input logic rst,
  prover_chi_expand_if.slave bus
);

  localparam int TBL = 1 << nBits;
  localparam int KW = $clog2(nBits) + 1;
  localparam int IW = nBits;
`ifdef PROVER_CHI_LEVEL0_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit INIT_DONE = BYP && (nBits == 1);

  state_t state_q;
  state_t state_d;
  logic   en_dly;
  logic   start;
  logic   last;

  logic [nBits-1:0][F_NBITS-1:0] z_q;
  logic [nBits-1:0][F_NBITS-1:0] mz_q;
  logic [TBL-1:0][F_NBITS-1:0]   chi_q;
  logic [KW-1:0] k_q;
  logic [IW-1:0] i_q;
  logic [IW-1:0] hi_idx;

  logic [F_NBITS-1:0] zk;
  logic [F_NBITS-1:0] mzk;
  logic [F_NBITS-1:0] mul_b;
  logic [F_NBITS-1:0] mul_c;
  logic mul_en;
  logic mul_rp;
  logic mul_rdy;

  assign start = bus.en & ~en_dly;
  assign last = (i_q == '0) && (k_q == KW'(nBits - 1));
  assign hi_idx = i_q + (IW'(1) << k_q);

  // pick coordinate k out of the latched vectors
  always_comb begin
    zk = '0;
    mzk = '0;
    for (int j = 0; j < nBits; j++) begin
      if (k_q == KW'(j)) begin
        zk = z_q[j];
        mzk = mz_q[j];
      end
    end
  end

  assign mul_b = (state_q == ST_LO_ST) ? mzk : zk;

  field_multiplier #(
    .LAT(MUL_LAT)
  ) u_mul (
    .clk(clk),
    .rstb(~rst),
    .en(mul_en),
    .a(chi_q[i_q]),
    .b(mul_b),
    .ready_pulse(mul_rp),
    .ready(mul_rdy),
    .c(mul_c)
  );

  // state and edge-detect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_dly <= 1'b1;
    end else begin
      state_q <= state_d;
      en_dly <= bus.en;
    end
  end

  // sequencer next state and multiplier issue
  always_comb begin
    state_d = state_q;
    mul_en = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (start) state_d = ST_INIT;
      ST_INIT:
        state_d = INIT_DONE ? ST_IDLE : ST_HI_ST;
      ST_HI_ST:
        if (mul_rdy) begin
          mul_en = 1'b1;
          state_d = ST_HI;
        end
      ST_HI:
        if (mul_rp) state_d = ST_LO_ST;
      ST_LO_ST:
        if (mul_rdy) begin
          mul_en = 1'b1;
          state_d = ST_LO;
        end
      ST_LO:
        if (mul_rp) state_d = ST_NEXT;
      ST_NEXT:
        state_d = last ? ST_IDLE : ST_HI_ST;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // input latch, table writes and level/index walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= '0;
      mz_q <= '0;
      chi_q <= '0;
      k_q <= '0;
      i_q <= '0;
    end else begin
      if (start && state_q == ST_IDLE) begin
        z_q <= bus.z;
        mz_q <= bus.m_z_p1;
      end
      unique case (state_q)
        ST_INIT: begin
          chi_q <= '0;
`ifdef PROVER_CHI_LEVEL0_BYPASS_EN
          chi_q[0] <= mz_q[0];
          chi_q[1] <= z_q[0];
          k_q <= KW'(1);
          i_q <= IW'(1);
`else
          chi_q[0] <= F_NBITS'(1);
          k_q <= '0;
          i_q <= '0;
`endif
        end
        ST_HI:
          if (mul_rp) chi_q[hi_idx] <= mul_c;
        ST_LO:
          if (mul_rp) chi_q[i_q] <= mul_c;
        ST_NEXT:
          if (i_q != '0) begin
            i_q <= i_q - IW'(1);
          end else if (!last) begin
            k_q <= k_q + KW'(1);
            i_q <= (IW'(1) << (k_q + KW'(1))) - IW'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.chi = chi_q;
  assign bus.ready = (state_q == ST_IDLE) & ~start;
  assign bus.ready_pulse =
    ((state_q == ST_NEXT) && last) ||
    (INIT_DONE && (state_q == ST_INIT));

endmodule

// File: tb/tb_prover_chi_expand.sv
// tb_prover_chi_expand: randomized runs against a
// product-of-coordinates reference of the chi table.
module tb_prover_chi_expand;
  import prover_chi_pkg::*;

  localparam int NB = 2;
  localparam int NT = 1 << NB;
  localparam int L = MUL_LAT;

  typedef logic [NB-1:0][F_NBITS-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;

  prover_chi_expand_if #(.NBITS(NB)) bus();

  prover_chi_expand #(
    .nBits(NB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [F_NBITS-1:0] ref_entry(
    input vec_t zz, input vec_t mm, input int idx);
    logic [127:0] acc;
    logic [127:0] pw;
    acc = 128'd1;
    pw = {67'd0, P};
    for (int j = 0; j < NB; j++)
      acc = (acc * {67'd0, (idx[j] ? zz[j] : mm[j])}) % pw;
    return acc[F_NBITS-1:0];
  endfunction

  function automatic int exp_lat();
    int s;
    int k0;
    s = 1;
    k0 = 0;
`ifdef PROVER_CHI_LEVEL0_BYPASS_EN
    k0 = 1;
`endif
    for (int k = k0; k < NB; k++)
      s += (1 << k) * (2 * (L + 1) + 1);
    return s;
  endfunction

  function automatic logic [F_NBITS-1:0] rand_elem();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r % {3'd0, P};
    return r[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] one_minus(
    input logic [F_NBITS-1:0] v);
    logic [63:0] t;
    t = ({3'd0, P} + 64'd1 - {3'd0, v}) % {3'd0, P};
    return t[F_NBITS-1:0];
  endfunction

  task automatic scramble_inputs();
    for (int j = 0; j < NB; j++) begin
      bus.z[j] = rand_elem();
      bus.m_z_p1[j] = rand_elem();
    end
  endtask

  task automatic do_run(input vec_t zz, input vec_t mm,
                        output int lat, output logic rdy_t);
    @(negedge clk);
    bus.z = zz;
    bus.m_z_p1 = mm;
    bus.en = 1'b1;
    #1 rdy_t = bus.ready;
    @(negedge clk);
    bus.en = 1'b0;
    scramble_inputs();
    lat = 1;
    while (lat < 200 && bus.ready_pulse !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.z = '0;
    bus.m_z_p1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.ready !== 1'b1)
      $display("FAIL reset_ready got %b want 1", bus.ready);
    else n_pass++;
    n_total++;
    if (bus.ready_pulse !== 1'b0)
      $display("FAIL reset_pulse got %b want 0", bus.ready_pulse);
    else n_pass++;
    for (int e = 0; e < NT; e++) begin
      n_total++;
      if (bus.chi[e] !== '0)
        $display("FAIL reset_chi[%0d] got %0d want 0", e, bus.chi[e]);
      else n_pass++;
    end
  endtask

  task automatic test_plan();
    vec_t zs [3];
    vec_t ms [3];
    logic [F_NBITS-1:0] lit [NT];
    int lat;
    logic rdy_t;
    zs[0][0] = 3;  zs[0][1] = 5;
    ms[0][0] = P - 2;  ms[0][1] = P - 4;
    zs[1][0] = 0;  zs[1][1] = 0;
    ms[1][0] = 1;  ms[1][1] = 1;
    zs[2][0] = 1;  zs[2][1] = 1;
    ms[2][0] = 0;  ms[2][1] = 0;
    lit[0] = 8;
    lit[1] = P - 12;
    lit[2] = P - 10;
    lit[3] = 15;
    for (int t = 0; t < 3; t++) begin
      do_run(zs[t], ms[t], lat, rdy_t);
      n_total++;
      if (lat !== exp_lat())
        $display("FAIL plan%0d_latency got %0d want %0d", t, lat, exp_lat());
      else n_pass++;
      n_total++;
      if (rdy_t !== 1'b0)
        $display("FAIL plan%0d_ready_at_start got %b want 0", t, rdy_t);
      else n_pass++;
      for (int e = 0; e < NT; e++) begin
        n_total++;
        if (bus.chi[e] !== ref_entry(zs[t], ms[t], e))
          $display("FAIL plan%0d_chi[%0d] got %0d want %0d",
                   t, e, bus.chi[e], ref_entry(zs[t], ms[t], e));
        else n_pass++;
        if (t == 0) begin
          n_total++;
          if (bus.chi[e] !== lit[e])
            $display("FAIL plan_literal_chi[%0d] got %0d want %0d",
                     e, bus.chi[e], lit[e]);
          else n_pass++;
        end
      end
      @(negedge clk);
      n_total++;
      if (bus.ready !== 1'b1 || bus.ready_pulse !== 1'b0)
        $display("FAIL plan%0d_after got rdy=%b pulse=%b want 1/0",
                 t, bus.ready, bus.ready_pulse);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    vec_t zz;
    vec_t mm;
    int lat;
    logic rdy_t;
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < NB; j++) begin
        zz[j] = rand_elem();
        mm[j] = one_minus(zz[j]);
      end
      do_run(zz, mm, lat, rdy_t);
      n_total++;
      if (lat !== exp_lat())
        $display("FAIL rand%0d_latency got %0d want %0d", t, lat, exp_lat());
      else n_pass++;
      repeat (3) @(negedge clk);
      for (int e = 0; e < NT; e++) begin
        n_total++;
        if (bus.chi[e] !== ref_entry(zz, mm, e))
          $display("FAIL rand%0d_chi[%0d] got %0d want %0d",
                   t, e, bus.chi[e], ref_entry(zz, mm, e));
        else n_pass++;
      end
    end
  endtask

  task automatic test_held_en();
    vec_t zz;
    vec_t mm;
    int pulses;
    int busy;
    int busy_mid;
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    busy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.ready_pulse === 1'b1) pulses++;
      if (bus.ready !== 1'b1) busy++;
    end
    n_total++;
    if (pulses != 0)
      $display("FAIL held_en_pulses got %0d want 0", pulses);
    else n_pass++;
    n_total++;
    if (busy != 0)
      $display("FAIL held_en_busy got %0d want 0", busy);
    else n_pass++;
    bus.en = 1'b0;
    for (int j = 0; j < NB; j++) begin
      zz[j] = rand_elem();
      mm[j] = one_minus(zz[j]);
    end
    @(negedge clk);
    bus.z = zz;
    bus.m_z_p1 = mm;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    pulses = 0;
    busy_mid = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.ready_pulse === 1'b1) pulses++;
      if (c == 6) begin
        bus.en = 1'b1;
        scramble_inputs();
      end
      if (c == 7 && bus.ready !== 1'b1) busy_mid = 1;
      if (c == 8) bus.en = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (pulses != 1)
      $display("FAIL toggle_pulses got %0d want 1", pulses);
    else n_pass++;
    n_total++;
    if (busy_mid != 1)
      $display("FAIL toggle_busy_mid got %0d want 1", busy_mid);
    else n_pass++;
    for (int e = 0; e < NT; e++) begin
      n_total++;
      if (bus.chi[e] !== ref_entry(zz, mm, e))
        $display("FAIL toggle_chi[%0d] got %0d want %0d",
                 e, bus.chi[e], ref_entry(zz, mm, e));
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    vec_t zz;
    vec_t mm;
    int lat;
    logic rdy_t;
    zz[0] = 3;  zz[1] = 5;
    mm[0] = P - 2;  mm[1] = P - 4;
    @(negedge clk);
    bus.z = zz;
    bus.m_z_p1 = mm;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.ready !== 1'b1 || bus.ready_pulse !== 1'b0)
      $display("FAIL abort_flags got rdy=%b pulse=%b want 1/0",
               bus.ready, bus.ready_pulse);
    else n_pass++;
    for (int e = 0; e < NT; e++) begin
      n_total++;
      if (bus.chi[e] !== '0)
        $display("FAIL abort_chi[%0d] got %0d want 0", e, bus.chi[e]);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_run(zz, mm, lat, rdy_t);
    n_total++;
    if (lat !== exp_lat())
      $display("FAIL rerun_latency got %0d want %0d", lat, exp_lat());
    else n_pass++;
    for (int e = 0; e < NT; e++) begin
      n_total++;
      if (bus.chi[e] !== ref_entry(zz, mm, e))
        $display("FAIL rerun_chi[%0d] got %0d want %0d",
                 e, bus.chi[e], ref_entry(zz, mm, e));
      else n_pass++;
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.z = '0;
    bus.m_z_p1 = '0;
    test_reset();
    test_plan();
    test_random();
    test_held_en();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
